// File: rtl/gate_strobe_gen.sv
// gate_strobe_gen
// Event-triggered strobe sequencer for the kicker gate drivers. A matching
// event code starts a sequence: a programmable delay, then a burst of
// single-cycle strobes separated by a programmable spacing, then a holdoff
// during which further matches are ignored and counted.
//
// Ports
//   kgdClk       in   word clock, the only clock
//   kgdReset     in   asynchronous active-high reset
//   evCode       in   event code from the event receiver
//   evCodeValid  in   evCode valid this cycle
//   enable       in   generator enable; low aborts any activity
//   triggerCode  in   event code that starts a sequence
//   delay        in   cycles from match to first strobe, minus one
//   burstCount   in   strobes per sequence, minus one
//   spacing      in   cycles between strobes, minus one
//   holdoff      in   dead cycles after the last strobe
//   clearMissed  in   clears missedCount (wins over an increment)
//   kgdStrobe    out  registered single-cycle strobe
//   busy         out  high whenever the sequencer is not idle
//   missedCount  out  saturating count of ignored matches
//
// state   | meaning
// IDLE    | waiting for a match
// DELAY   | counting down the trigger-to-first-strobe delay
// BURST   | strobe cycle (kgdStrobe is high in every BURST cycle)
// SPACE   | counting down the gap between strobes
// HOLDOFF | dead time after the last strobe
module gate_strobe_gen #(
    parameter int DELAY_WIDTH   = 16,
    parameter int SPACING_WIDTH = 8,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     kgdClk,
    input  logic                     kgdReset,
    input  logic [7:0]               evCode,
    input  logic                     evCodeValid,
    input  logic                     enable,
    input  logic [7:0]               triggerCode,
    input  logic [DELAY_WIDTH-1:0]   delay,
    input  logic [3:0]               burstCount,
    input  logic [SPACING_WIDTH-1:0] spacing,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    input  logic                     clearMissed,
    output logic                     kgdStrobe,
    output logic                     busy,
    output logic [7:0]               missedCount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        BURST   = 3'd2,
        SPACE   = 3'd3,
        HOLDOFF = 3'd4
    } stateType;

    localparam logic [DELAY_WIDTH-1:0]   DLY_ONE  = 1;
    localparam logic [SPACING_WIDTH-1:0] SPC_ONE  = 1;
    localparam logic [HOLDOFF_WIDTH-1:0] HLD_ONE  = 1;

    stateType                 state;
    logic [DELAY_WIDTH-1:0]   delayCnt;
    logic [SPACING_WIDTH-1:0] spaceCnt;
    logic [HOLDOFF_WIDTH-1:0] holdCnt;
    logic [SPACING_WIDTH-1:0] spacingReg;
    logic [HOLDOFF_WIDTH-1:0] holdoffReg;
    logic [3:0]               strobesLeft;
    logic                     match;

    assign match = enable & evCodeValid & (evCode == triggerCode);
    assign busy  = (state != IDLE);

    // The strobe is registered, so it is set on the edge that enters a BURST
    // cycle. Counters are loaded with (count - 1) so that a state with
    // count N occupies exactly N cycles; a zero count skips the state.
    always_ff @(posedge kgdClk or posedge kgdReset) begin
        if (kgdReset) begin
            state       <= IDLE;
            kgdStrobe   <= 1'b0;
            missedCount <= 8'd0;
            delayCnt    <= '0;
            spaceCnt    <= '0;
            holdCnt     <= '0;
            spacingReg  <= '0;
            holdoffReg  <= '0;
            strobesLeft <= 4'd0;
        end else begin
            kgdStrobe <= 1'b0;

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (match) begin
                            spacingReg  <= spacing;
                            holdoffReg  <= holdoff;
                            strobesLeft <= burstCount;
                            if (delay == '0) begin
                                state     <= BURST;
                                kgdStrobe <= 1'b1;
                            end else begin
                                state    <= DELAY;
                                delayCnt <= delay - DLY_ONE;
                            end
                        end
                    end
                    DELAY: begin
                        if (delayCnt == '0) begin
                            state     <= BURST;
                            kgdStrobe <= 1'b1;
                        end else begin
                            delayCnt <= delayCnt - DLY_ONE;
                        end
                    end
                    BURST: begin
                        if (strobesLeft == 4'd0) begin
                            if (holdoffReg == '0) begin
                                state <= IDLE;
                            end else begin
                                state   <= HOLDOFF;
                                holdCnt <= holdoffReg - HLD_ONE;
                            end
                        end else begin
                            strobesLeft <= strobesLeft - 4'd1;
                            if (spacingReg == '0) begin
                                kgdStrobe <= 1'b1;
                            end else begin
                                state    <= SPACE;
                                spaceCnt <= spacingReg - SPC_ONE;
                            end
                        end
                    end
                    SPACE: begin
                        if (spaceCnt == '0) begin
                            state     <= BURST;
                            kgdStrobe <= 1'b1;
                        end else begin
                            spaceCnt <= spaceCnt - SPC_ONE;
                        end
                    end
                    HOLDOFF: begin
                        if (holdCnt == '0) begin
                            state <= IDLE;
                        end else begin
                            holdCnt <= holdCnt - HLD_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // match already includes enable, so nothing is counted while disabled
            if (clearMissed) begin
                missedCount <= 8'd0;
            end else if (match && (state != IDLE) && (missedCount != 8'hFF)) begin
                missedCount <= missedCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gate_strobe_gen.sv
module tb_gate_strobe_gen;

    localparam int DW = 16;
    localparam int SW = 8;
    localparam int HW = 16;

    logic          kgdClk;
    logic          kgdReset;
    logic [7:0]    evCode;
    logic          evCodeValid;
    logic          enable;
    logic [7:0]    triggerCode;
    logic [DW-1:0] delay;
    logic [3:0]    burstCount;
    logic [SW-1:0] spacing;
    logic [HW-1:0] holdoff;
    logic          clearMissed;
    logic          kgdStrobe;
    logic          busy;
    logic [7:0]    missedCount;

    int checks = 0;
    int errors = 0;

    gate_strobe_gen #(
        .DELAY_WIDTH  (DW),
        .SPACING_WIDTH(SW),
        .HOLDOFF_WIDTH(HW)
    ) dut (
        .kgdClk      (kgdClk),
        .kgdReset    (kgdReset),
        .evCode      (evCode),
        .evCodeValid (evCodeValid),
        .enable      (enable),
        .triggerCode (triggerCode),
        .delay       (delay),
        .burstCount  (burstCount),
        .spacing     (spacing),
        .holdoff     (holdoff),
        .clearMissed (clearMissed),
        .kgdStrobe   (kgdStrobe),
        .busy        (busy),
        .missedCount (missedCount)
    );

    initial kgdClk = 1'b0;
    always #5 kgdClk = ~kgdClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge kgdClk);
        #1;
    endtask

    initial begin
        kgdReset    = 1'b1;
        evCode      = 8'h00;
        evCodeValid = 1'b0;
        enable      = 1'b1;
        triggerCode = 8'h7D;
        delay       = '0;
        burstCount  = 4'd0;
        spacing     = '0;
        holdoff     = '0;
        clearMissed = 1'b0;
        step();
        step();
        chk("rst strobe", kgdStrobe, 0);
        chk("rst busy", busy, 0);
        chk("rst missed", missedCount, 0);
        kgdReset = 1'b0;
        step();

        // single strobe, delay 5; a wrong code at cycle 5 must not trigger
        delay = 16'd5; burstCount = 4'd0; holdoff = '0; spacing = '0;
        for (int c = 0; c <= 20; c++) begin
            chk($sformatf("t1 strobe c%0d", c), kgdStrobe, (c == 16));
            chk($sformatf("t1 busy c%0d", c), busy, (c >= 11 && c <= 16));
            evCode      = (c == 5) ? 8'h7C : 8'h7D;
            evCodeValid = (c == 5 || c == 10);
            step();
        end
        evCodeValid = 1'b0;

        // burst of 4 with spacing 2; config changes mid-sequence are ignored
        delay = '0; burstCount = 4'd3; spacing = 8'd2; holdoff = '0;
        for (int c = 0; c <= 14; c++) begin
            chk($sformatf("t2 strobe c%0d", c), kgdStrobe, (c == 1 || c == 4 || c == 7 || c == 10));
            chk($sformatf("t2 busy c%0d", c), busy, (c >= 1 && c <= 10));
            evCodeValid = (c == 0);
            if (c == 2) begin
                spacing = 8'd0; burstCount = 4'd0; holdoff = 16'd9;
            end
            step();
        end
        evCodeValid = 1'b0;

        // spacing 0 burst, holdoff 4, ignored matches at 2 and 6, restart at 8
        delay = '0; burstCount = 4'd2; spacing = '0; holdoff = 16'd4;
        for (int c = 0; c <= 16; c++) begin
            chk($sformatf("t3 strobe c%0d", c), kgdStrobe,
                (c >= 1 && c <= 3) || (c >= 9 && c <= 11));
            chk($sformatf("t3 busy c%0d", c), busy, (c >= 1 && c <= 7) || (c >= 9 && c <= 15));
            if (c == 3) chk("t3 missed c3", missedCount, 1);
            if (c == 8) chk("t3 missed c8", missedCount, 2);
            evCodeValid = (c == 0 || c == 2 || c == 6 || c == 8);
            step();
        end
        evCodeValid = 1'b0;
        clearMissed = 1'b1;
        step();
        clearMissed = 1'b0;
        chk("t3 cleared", missedCount, 0);

        // delay 100, abort by enable low at 50, restart at 60
        delay = 16'd100; burstCount = 4'd0; spacing = '0; holdoff = '0;
        for (int c = 0; c <= 165; c++) begin
            chk($sformatf("t4 strobe c%0d", c), kgdStrobe, (c == 161));
            chk($sformatf("t4 busy c%0d", c), busy, (c >= 1 && c <= 50) || (c >= 61 && c <= 161));
            enable      = !(c >= 50 && c < 55);
            evCodeValid = (c == 0 || c == 52 || c == 60);
            step();
        end
        evCodeValid = 1'b0;
        enable      = 1'b1;
        chk("t4 missed", missedCount, 0);

        // saturation of missedCount during a long holdoff, then clear vs match
        delay = '0; burstCount = 4'd0; spacing = '0; holdoff = 16'd1000;
        for (int c = 0; c <= 305; c++) begin
            if (c == 1)   chk("t5 strobe c1", kgdStrobe, 1);
            if (c == 256) chk("t5 missed c256", missedCount, 254);
            if (c == 257) chk("t5 missed c257", missedCount, 255);
            if (c == 302) chk("t5 missed c302", missedCount, 255);
            if (c == 304) chk("t5 missed c304", missedCount, 0);
            if (c == 305) chk("t5 busy c305", busy, 1);
            evCodeValid = (c == 0) || (c >= 2 && c <= 303);
            clearMissed = (c == 303);
            step();
        end
        evCodeValid = 1'b0;
        clearMissed = 1'b0;
        enable = 1'b0;
        step();
        enable = 1'b1;
        chk("t5 abort busy", busy, 0);

        // asynchronous reset in the middle of a burst
        delay = 16'd2; burstCount = 4'd3; spacing = 8'd1; holdoff = '0;
        for (int c = 0; c <= 4; c++) begin
            chk($sformatf("t6 strobe c%0d", c), kgdStrobe, (c == 3));
            evCodeValid = (c == 0);
            step();
        end
        evCodeValid = 1'b0;
        chk("t6 strobe c5", kgdStrobe, 1);
        chk("t6 busy c5", busy, 1);
        #2 kgdReset = 1'b1;
        #1;
        chk("t6 async strobe", kgdStrobe, 0);
        chk("t6 async busy", busy, 0);
        kgdReset = 1'b0;
        step();
        for (int c = 6; c <= 14; c++) begin
            chk($sformatf("t6 post strobe c%0d", c), kgdStrobe, 0);
            chk($sformatf("t6 post busy c%0d", c), busy, 0);
            step();
        end
        for (int c = 0; c <= 11; c++) begin
            chk($sformatf("t6 new strobe c%0d", c), kgdStrobe, (c == 3 || c == 5 || c == 7 || c == 9));
            chk($sformatf("t6 new busy c%0d", c), busy, (c >= 1 && c <= 9));
            evCodeValid = (c == 0);
            step();
        end
        evCodeValid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
